// File: rtl/ghostchip_pkg.sv
// Shared framebuffer geometry, arbiter state encoding and RAM-port payload.
package ghostchip_pkg;

  localparam int unsigned FB_ROWS       = 32;
  localparam int unsigned FB_COLS_BYTES = 8;
  localparam int unsigned FB_AW         = 8;
  localparam int unsigned FB_DW         = 8;
  localparam int unsigned POS_W         = 9;
  localparam int unsigned ROW_W         = $clog2(FB_ROWS);
  localparam int unsigned COL_W         = $clog2(FB_COLS_BYTES);
  localparam int unsigned PIX_IDX_W     = 3;
  localparam int unsigned FB_LAST       = FB_ROWS * FB_COLS_BYTES - 1;

  typedef logic [FB_AW-1:0] fb_addr_t;
  typedef logic [FB_DW-1:0] fb_data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    CLEAR = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic     we;
    fb_addr_t addr;
    fb_data_t wdata;
  } ram_req_t;

endpackage

// File: rtl/vram_pixel_serializer.sv
// Captures each fetched framebuffer byte and shifts out one pixel per scaled column.
module vram_pixel_serializer
  import ghostchip_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  fb_data_t             ram_rdata,
  input  logic                 load,
  input  logic [PIX_IDX_W-1:0] hpos,
  input  logic                 in_win,
  output logic                 pixel
);

  logic                 load_d1;
  fb_data_t             byte_reg;
  logic [PIX_IDX_W-1:0] idx_d1;
  logic [PIX_IDX_W-1:0] idx_d2;
  logic                 win_d1;
  logic                 win_d2;

  // RAM data lands one cycle after the video slot; the position pipeline matches that plus the byte load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_d1  <= 1'b0;
      byte_reg <= '0;
      idx_d1   <= '0;
      idx_d2   <= '0;
      win_d1   <= 1'b0;
      win_d2   <= 1'b0;
    end else begin
      load_d1 <= load;
      if (load_d1) begin
        byte_reg <= ram_rdata;
      end
      idx_d1 <= hpos;
      idx_d2 <= idx_d1;
      win_d1 <= in_win;
      win_d2 <= win_d1;
    end
  end

  // MSB is the leftmost pixel of the byte.
  assign pixel = win_d2 & byte_reg[PIX_IDX_W'(7) - idx_d2];

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates the single-port framebuffer between scanout, the clear engine and the CPU.
module vram_arbiter
  import ghostchip_pkg::*;
#(
  parameter int unsigned V_OFFSET    = 56,
  parameter int unsigned SCALE_SHIFT = 2
)(
  input  logic             clk,
  input  logic             reset,
  input  logic [POS_W-1:0] hpos,
  input  logic [POS_W-1:0] vpos,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  fb_addr_t         cpu_addr,
  input  fb_data_t         cpu_wdata,
  output logic             cpu_ack,
  output fb_data_t         cpu_rdata,
  input  logic             clr_start,
  output logic             clr_busy,
  output fb_addr_t         ram_addr,
  output logic             ram_we,
  output fb_data_t         ram_wdata,
  input  fb_data_t         ram_rdata,
  output logic             pixel
);

  localparam int unsigned WIN_W = (FB_COLS_BYTES * 8) << SCALE_SHIFT;
  localparam int unsigned WIN_H = FB_ROWS << SCALE_SHIFT;

  arb_state_t       state;
  arb_state_t       state_nx;
  fb_addr_t         clr_cnt;
  fb_addr_t         clr_cnt_nx;
  logic             clr_pend;
  logic             clr_pend_nx;
  logic             cpu_grant_c;
  logic             clr_grant_c;
  logic             in_win_c;
  logic             video_slot_c;
  logic [POS_W-1:0] v_rel;
  fb_addr_t         video_addr;
  ram_req_t         port_c;

  assign v_rel        = vpos - POS_W'(V_OFFSET);
  assign in_win_c     = (hpos < POS_W'(WIN_W)) && (vpos >= POS_W'(V_OFFSET)) &&
                        (vpos < POS_W'(V_OFFSET + WIN_H));
  assign video_slot_c = in_win_c && (hpos[SCALE_SHIFT+2:0] == '0);
  assign video_addr   = {ROW_W'(v_rel >> SCALE_SHIFT), COL_W'(hpos >> (SCALE_SHIFT + 3))};

  // Next-state and grant decode; video slots pre-empt both clear writes and CPU grants.
  always_comb begin
    state_nx    = state;
    clr_cnt_nx  = clr_cnt;
    clr_pend_nx = clr_pend;
    cpu_grant_c = 1'b0;
    clr_grant_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (clr_start || clr_pend) begin
          state_nx    = CLEAR;
          clr_cnt_nx  = '0;
          clr_pend_nx = 1'b0;
        end else if (cpu_req && !video_slot_c) begin
          cpu_grant_c = 1'b1;
          state_nx    = ACK;
        end
      end
      ACK: begin
        if (clr_start) begin
          clr_pend_nx = 1'b1;
        end
        state_nx = IDLE;
      end
      CLEAR: begin
        if (!video_slot_c) begin
          clr_grant_c = 1'b1;
          clr_cnt_nx  = clr_cnt + fb_addr_t'(1);
          if (clr_cnt == fb_addr_t'(FB_LAST)) begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, clear counter, pending start and the registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      clr_cnt  <= '0;
      clr_pend <= 1'b0;
      cpu_ack  <= 1'b0;
      clr_busy <= 1'b0;
    end else begin
      state    <= state_nx;
      clr_cnt  <= clr_cnt_nx;
      clr_pend <= clr_pend_nx;
      cpu_ack  <= (state_nx == ACK);
      clr_busy <= (state_nx == CLEAR) || clr_pend_nx;
    end
  end

  // RAM port mux of the current cycle's winner; idle port reads address 0.
  always_comb begin
    port_c = '0;
    if (video_slot_c) begin
      port_c.addr = video_addr;
    end else if (clr_grant_c) begin
      port_c.we   = 1'b1;
      port_c.addr = clr_cnt;
    end else if (cpu_grant_c) begin
      port_c.we    = cpu_we;
      port_c.addr  = cpu_addr;
      port_c.wdata = cpu_wdata;
    end
  end

  assign ram_addr  = port_c.addr;
  assign ram_we    = port_c.we;
  assign ram_wdata = port_c.wdata;
  assign cpu_rdata = (state == ACK) ? ram_rdata : '0;

  vram_pixel_serializer u_serializer (
    .clk       (clk),
    .reset     (reset),
    .ram_rdata (ram_rdata),
    .load      (video_slot_c),
    .hpos      (hpos[SCALE_SHIFT+2:SCALE_SHIFT]),
    .in_win    (in_win_c),
    .pixel     (pixel)
  );

endmodule
